noekeon_round_ctrl: RTL and testbench
=====================================

NOEKEON_ROUND_CTRL -- requirements
Module: noekeon_round_ctrl

Interface
REQ-001 SHALL have parameter NROUNDS, default 16, number of round iterations.
REQ-002 SHALL have ports: inClk  in  1  clock, all state updates on rising edge.
REQ-003 SHALL have port inRst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports inStart (in, 1, start request), inDecipher (in, 1, 0 encrypt / 1 decrypt), inData (in, 128, block), inKey (in, 128, cipher key).
REQ-005 SHALL have round-datapath ports: outRoundData (out, 128), outRoundKey (out, 128), outRoundconst (out, 8), outDecipher (out, 1), inRoundResult (in, 128, combinational result of external round stage).
REQ-006 SHALL have theta ports: outThetaData (out, 128), outThetaKey (out, 128), inThetaResult (in, 128, combinational result of external Theta stage).
REQ-007 SHALL have outputs outBusy (out, 1), outValid (out, 1, one-cycle done pulse) and outData (out, 128, registered result).

Function
REQ-008 SHALL implement states IDLE, KEYPREP, ROUND, FINAL.
REQ-009 In IDLE with inStart=1, SHALL capture inData into the state register, inKey into the working-key register and inDecipher into the mode register; SHALL clear the round counter.
REQ-010 After capture, SHALL enter KEYPREP if mode=1, otherwise ROUND.
REQ-011 KEYPREP (1 cycle): SHALL drive outThetaData=working key and outThetaKey=0; SHALL load the working key with inThetaResult; SHALL then enter ROUND.
REQ-012 ROUND: SHALL drive outRoundData=state, outRoundKey=working key, outDecipher=mode and outRoundconst=current constant; SHALL load state with inRoundResult every cycle; SHALL increment the counter.
REQ-013 SHALL leave ROUND for FINAL after exactly NROUNDS ROUND cycles.
REQ-014 Encrypt constants: SHALL start at 0x80 and advance per round as rc'=(rc<<1)^(rc[7]?0x1B:0x00), truncated to 8 bits.
REQ-015 Decrypt constants: SHALL start at 0xD4 and advance as rc'=rc[0]?(((rc^0x1B)>>1)|0x80):(rc>>1).
REQ-016 Encrypt FINAL: SHALL drive outThetaData={state[127:8], state[7:0]^0xD4} and outThetaKey=working key; SHALL load outData=inThetaResult.
REQ-017 Decrypt FINAL: SHALL drive outThetaData=state and outThetaKey=working key; SHALL load outData={inThetaResult[127:8], inThetaResult[7:0]^0x80}.
REQ-018 FINAL SHALL last 1 cycle, assert outValid for the following cycle only and return to IDLE.
REQ-019 outBusy SHALL be 1 in every state except IDLE.
REQ-020 Latency SHALL be: start edge to outValid high = NROUNDS+2 cycles (encrypt) and NROUNDS+3 cycles (decrypt).
REQ-021 inStart while outBusy=1 SHALL be ignored, with no effect on state, key or counter.
REQ-022 inStart asserted in the same cycle as outValid SHALL be accepted (state is IDLE).
REQ-023 outData SHALL hold its value until the next FINAL.
REQ-024 Round and theta output ports SHALL be 0 whenever they are unused in the current state.
REQ-025 The counter SHALL be wide enough for NROUNDS and SHALL NOT wrap inside an operation.

Reset
REQ-026 While inRst_n=0 (asynchronously), state SHALL be IDLE and outBusy, outValid, outData, counter, state and key registers, and all round/theta outputs SHALL be 0.
REQ-027 Reset mid-operation SHALL abort the operation with no outValid; the first start after release SHALL behave as from power-up.

Verification
REQ-028 Encrypt start, NROUNDS=16 -> outRoundconst sequence 80,1B,36,6C,D8,AB,4D,9A,2F,5E,BC,63,C6,97,35,6A; FINAL xor 0xD4; outValid at cycle 18.
REQ-029 Decrypt start -> one KEYPREP with outThetaKey=0; constants D4,6A,35,97,C6,63,BC,5E,2F,9A,4D,AB,D8,6C,36,1B; final low byte xor 0x80; outValid at cycle 19.
REQ-030 With bench round/theta models, encrypt then decrypt of data=0, key=0 and of random vectors -> recovered plaintext equals input.
REQ-031 inStart pulsed at cycles 5 and 10 of a run -> ignored; exactly one outValid; outData unchanged by the extra pulses.
REQ-032 inRst_n low at cycle 8 -> immediate zero outputs and IDLE; subsequent encrypt completes in 18 cycles.
REQ-033 inStart held high continuously -> back-to-back operations, with outValid every 18 cycles (encrypt).

Source files
------------

// File: rtl/noekeon_round_ctrl_if.sv
// Purpose: groups the start/data/key request, the external round and theta stage
//          taps, and the busy/done/result returns of noekeon_round_ctrl.
// Latency: wires only. Backpressure: none; inStart is ignored while outBusy is high.
// Ports: slave = controller side, master = driver side (supplies data, key and the
//        combinational round/theta stage results).
interface noekeon_round_ctrl_if;
    logic         inStart;
    logic         inDecipher;
    logic [127:0] inData;
    logic [127:0] inKey;
    logic [127:0] outRoundData;
    logic [127:0] outRoundKey;
    logic [7:0]   outRoundconst;
    logic         outDecipher;
    logic [127:0] inRoundResult;
    logic [127:0] outThetaData;
    logic [127:0] outThetaKey;
    logic [127:0] inThetaResult;
    logic         outBusy;
    logic         outValid;
    logic [127:0] outData;

    modport slave (
        input  inStart, inDecipher, inData, inKey, inRoundResult, inThetaResult,
        output outRoundData, outRoundKey, outRoundconst, outDecipher,
               outThetaData, outThetaKey, outBusy, outValid, outData
    );

    modport master (
        output inStart, inDecipher, inData, inKey, inRoundResult, inThetaResult,
        input  outRoundData, outRoundKey, outRoundconst, outDecipher,
               outThetaData, outThetaKey, outBusy, outValid, outData
    );
endinterface

// File: rtl/noekeon_round_ctrl.sv
// Purpose: sequences a NOEKEON encrypt/decrypt through external round and theta stages.
// Latency: start cycle to outValid = NROUNDS+2 (encrypt) / NROUNDS+3 (decrypt) cycles.
// Backpressure: none; a start while busy is dropped, a start during outValid is taken.
// Ports: inClk/inRst_n (async active-low); bus = request, round/theta taps, busy/valid/data.
module noekeon_round_ctrl #(
    parameter int NROUNDS = 16
) (
    input  logic                 inClk,
    input  logic                 inRst_n,
    noekeon_round_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, KEYPREP, ROUND, FINAL} state_t;

    localparam int CW = $clog2(NROUNDS + 1);

    state_t         fsm_q, fsm_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   key_q, key_d;
    logic           mode_q, mode_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     rc_q, rc_d;
    logic           valid_q, valid_d;
    logic [127:0]   out_q, out_d;

    logic [127:0]   round_data, round_key, theta_data, theta_key;
    logic [7:0]     round_const;
    logic           round_dec;

    // Encrypt constants walk forward through the GF(2^8) doubling sequence.
    function automatic logic [7:0] rc_fwd(input logic [7:0] rc);
        return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
    endfunction

    // Decrypt constants walk the same sequence backwards (inverse doubling).
    function automatic logic [7:0] rc_bwd(input logic [7:0] rc);
        return rc[0] ? (((rc ^ 8'h1B) >> 1) | 8'h80) : (rc >> 1);
    endfunction

    always_ff @(posedge inClk or negedge inRst_n) begin
        if (!inRst_n) begin
            fsm_q   <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            rc_q    <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            data_q  <= data_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        data_d      = data_q;
        key_d       = key_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        rc_d        = rc_q;
        valid_d     = 1'b0;
        out_d       = out_q;
        round_data  = '0;
        round_key   = '0;
        round_const = '0;
        round_dec   = 1'b0;
        theta_data  = '0;
        theta_key   = '0;

        case (fsm_q)
            IDLE: begin
                if (bus.inStart) begin
                    data_d = bus.inData;
                    key_d  = bus.inKey;
                    mode_d = bus.inDecipher;
                    cnt_d  = '0;
                    rc_d   = bus.inDecipher ? 8'hD4 : 8'h80;
                    fsm_d  = bus.inDecipher ? KEYPREP : ROUND;
                end
            end
            KEYPREP: begin
                // Decryption uses Theta(0, K) as its working key.
                theta_data = key_q;
                theta_key  = '0;
                key_d      = bus.inThetaResult;
                fsm_d      = ROUND;
            end
            ROUND: begin
                round_data  = data_q;
                round_key   = key_q;
                round_const = rc_q;
                round_dec   = mode_q;
                data_d      = bus.inRoundResult;
                cnt_d       = cnt_q + CW'(1);
                rc_d        = mode_q ? rc_bwd(rc_q) : rc_fwd(rc_q);
                if (cnt_q == CW'(NROUNDS - 1)) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                // Encrypt folds the last constant in before theta; decrypt folds
                // the first constant in after it.
                theta_key  = key_q;
                theta_data = mode_q ? data_q : {data_q[127:8], data_q[7:0] ^ 8'hD4};
                out_d      = mode_q ? {bus.inThetaResult[127:8], bus.inThetaResult[7:0] ^ 8'h80}
                                    : bus.inThetaResult;
                valid_d    = 1'b1;
                fsm_d      = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign bus.outRoundData  = round_data;
    assign bus.outRoundKey   = round_key;
    assign bus.outRoundconst = round_const;
    assign bus.outDecipher   = round_dec;
    assign bus.outThetaData  = theta_data;
    assign bus.outThetaKey   = theta_key;
    assign bus.outBusy       = (fsm_q != IDLE);
    assign bus.outValid      = valid_q;
    assign bus.outData       = out_q;
endmodule

// File: tb/tb_noekeon_round_ctrl.sv
// Purpose: directed bench for noekeon_round_ctrl with a reference NOEKEON round/theta model.
// Latency: checks 18-cycle encrypt / 19-cycle decrypt start-to-valid timing.
// Backpressure: exercises starts while busy, start on valid, and held start.
module tb_noekeon_round_ctrl;
    logic inClk;
    logic inRst_n;
    int   n_cmp;
    int   n_bad;

    noekeon_round_ctrl_if bus ();

    noekeon_round_ctrl #(.NROUNDS(16)) dut (
        .inClk   (inClk),
        .inRst_n (inRst_n),
        .bus     (bus)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    logic [127:0] enc_seq = 128'h801B366CD8AB4D9A2F5EBC63C697356A;
    logic [127:0] dec_seq = 128'hD46A3597C663BC5E2F9A4DABD86C361B;

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] theta_f(input logic [127:0] k, input logic [127:0] x);
        logic [31:0] a0, a1, a2, a3, t;
        {a3, a2, a1, a0} = x;
        t  = a0 ^ a2;
        t  = t ^ rl(t, 8) ^ rl(t, 24);
        a1 = a1 ^ t;
        a3 = a3 ^ t;
        a0 = a0 ^ k[31:0];
        a1 = a1 ^ k[63:32];
        a2 = a2 ^ k[95:64];
        a3 = a3 ^ k[127:96];
        t  = a1 ^ a3;
        t  = t ^ rl(t, 8) ^ rl(t, 24);
        a0 = a0 ^ t;
        a2 = a2 ^ t;
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] round_f(input logic [127:0] x, input logic [127:0] k,
                                             input logic [7:0] rc, input logic dec);
        logic [127:0] y;
        logic [31:0]  a0, a1, a2, a3, t;
        y = x;
        if (!dec) y[7:0] = y[7:0] ^ rc;
        y = theta_f(k, y);
        if (dec) y[7:0] = y[7:0] ^ rc;
        {a3, a2, a1, a0} = y;
        a1 = rl(a1, 1); a2 = rl(a2, 5); a3 = rl(a3, 2);
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        t  = a3; a3 = a0; a0 = t;
        a2 = a2 ^ a0 ^ a1 ^ a3;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        a1 = rl(a1, 31); a2 = rl(a2, 27); a3 = rl(a3, 30);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] noekeon_enc(input logic [127:0] p, input logic [127:0] k,
                                                 input logic [127:0] seq);
        logic [127:0] y;
        y = p;
        for (int i = 0; i < 16; i++) y = round_f(y, k, seq[127 - 8*i -: 8], 1'b0);
        y[7:0] = y[7:0] ^ 8'hD4;
        return theta_f(k, y);
    endfunction

    // External combinational round and theta stages.
    always_comb begin
        bus.inRoundResult = round_f(bus.outRoundData, bus.outRoundKey, bus.outRoundconst, bus.outDecipher);
        bus.inThetaResult = theta_f(bus.outThetaKey, bus.outThetaData);
    end

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One operation from the start cycle (cycle 0) to one cycle past outValid.
    task automatic run_op(input logic dec, input logic [127:0] d, input logic [127:0] k,
                          input logic [127:0] exp, input bit intrude);
        logic [15:0][7:0] seen;
        int c, lat, idx;
        seen = '0;
        lat  = -1;
        c    = 1;
        bus.inDecipher = dec;
        bus.inData     = d;
        bus.inKey      = k;
        bus.inStart    = 1'b1;
        tick();
        bus.inStart = 1'b0;
        while (c <= 40 && lat < 0) begin
            if (dec && c == 1) begin
                chk("keyprep_thetakey", bus.outThetaKey, '0);
                chk("keyprep_thetadata", bus.outThetaData, k);
            end
            if (c == 5) chk("round_theta_unused", bus.outThetaData | bus.outThetaKey, '0);
            idx = c - (dec ? 2 : 1);
            if (idx >= 0 && idx < 16) seen[15 - idx] = bus.outRoundconst;
            if (intrude && (c == 5 || c == 10)) begin
                bus.inStart    = 1'b1;
                bus.inData     = ~d;
                bus.inKey      = ~k;
                bus.inDecipher = ~dec;
            end else begin
                bus.inStart = 1'b0;
            end
            if (bus.outValid) lat = c;
            else begin
                tick();
                c++;
            end
        end
        chk("latency", 128'(lat), dec ? 128'd19 : 128'd18);
        chk("rc_seq", seen, dec ? dec_seq : enc_seq);
        chk("out_data", bus.outData, exp);
        tick();
        chk("valid_one_cycle", 128'(bus.outValid), '0);
        chk("idle_round_unused", bus.outRoundData | bus.outRoundKey | 128'(bus.outRoundconst)
                                 | 128'(bus.outDecipher) | 128'(bus.outBusy), '0);
        chk("out_hold", bus.outData, exp);
    endtask

    typedef struct {
        logic         dec;
        logic [127:0] data;
        logic [127:0] key;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [127:0] p1, k1, p2, k2, c0, c1, c2;
        int nv, vcnt;
        n_cmp = 0;
        n_bad = 0;

        p1 = 128'h0123456789ABCDEFFEDCBA9876543210;
        k1 = 128'h000102030405060708090A0B0C0D0E0F;
        p2 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        c0 = noekeon_enc('0, '0, enc_seq);
        c1 = noekeon_enc(p1, k1, enc_seq);
        c2 = noekeon_enc(p2, k2, enc_seq);
        tbl[0].dec = 1'b0; tbl[0].data = '0; tbl[0].key = '0; tbl[0].exp = c0;
        tbl[1].dec = 1'b1; tbl[1].data = c0; tbl[1].key = '0; tbl[1].exp = '0;
        tbl[2].dec = 1'b0; tbl[2].data = p1; tbl[2].key = k1; tbl[2].exp = c1;
        tbl[3].dec = 1'b1; tbl[3].data = c1; tbl[3].key = k1; tbl[3].exp = p1;
        tbl[4].dec = 1'b0; tbl[4].data = p2; tbl[4].key = k2; tbl[4].exp = c2;
        tbl[5].dec = 1'b1; tbl[5].data = c2; tbl[5].key = k2; tbl[5].exp = p2;

        inRst_n        = 1'b0;
        bus.inStart    = 1'b0;
        bus.inDecipher = 1'b0;
        bus.inData     = '0;
        bus.inKey      = '0;
        #2;
        chk("rst_busy_valid", {126'd0, bus.outBusy, bus.outValid}, '0);
        chk("rst_outdata", bus.outData, '0);
        chk("rst_round_outs", bus.outRoundData | bus.outRoundKey | 128'(bus.outRoundconst)
                              | 128'(bus.outDecipher), '0);
        chk("rst_theta_outs", bus.outThetaData | bus.outThetaKey, '0);
        tick();
        tick();
        inRst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_op(tbl[i].dec, tbl[i].data, tbl[i].key, tbl[i].exp, 1'b0);

        // Starts at cycles 5 and 10 of a run must be dropped.
        run_op(1'b0, p1, k1, c1, 1'b1);
        nv = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.outValid) nv++;
            tick();
        end
        chk("intrude_no_extra_valid", 128'(nv), '0);
        chk("intrude_outdata_hold", bus.outData, c1);

        // Asynchronous reset at cycle 8 aborts the operation.
        bus.inDecipher = 1'b0; bus.inData = p2; bus.inKey = k2; bus.inStart = 1'b1;
        tick();
        bus.inStart = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        inRst_n = 1'b0;
        #1;
        chk("midrst_busy", 128'(bus.outBusy), '0);
        chk("midrst_outdata", bus.outData, '0);
        chk("midrst_round_outs", bus.outRoundData | bus.outRoundKey | 128'(bus.outRoundconst), '0);
        tick();
        inRst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.outValid) nv++;
            tick();
        end
        chk("midrst_no_valid", 128'(nv), '0);
        run_op(1'b0, p1, k1, c1, 1'b0);

        // Held start: back-to-back encrypts, done pulses 18 cycles apart.
        bus.inDecipher = 1'b0; bus.inData = p2; bus.inKey = k2; bus.inStart = 1'b1;
        vcnt = 0;
        for (int c = 0; c <= 56; c++) begin
            if (bus.outValid) begin
                vcnt++;
                chk("b2b_valid_cycle", 128'(c), 128'(18 * vcnt));
                chk("b2b_outdata", bus.outData, c2);
            end
            tick();
        end
        chk("b2b_valid_count", 128'(vcnt), 128'd3);
        bus.inStart = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
